// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BUF  = 2'd2
  } if_state_t;

  // Bubble instruction: sll $0,$0,0
  localparam logic [31:0] IF_NOP      = 32'h0000_0000;
  localparam logic [31:0] IF_PC_INC   = 32'd4;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  // Word-align a fetch address; the two low bits carry no meaning.
  function automatic logic [31:0] if_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_unit_skid.sv
// One-entry holding register for an instruction word acked while IF/ID is stalled.
// Latency: a word loaded on one edge is readable from the next cycle on.
// Backpressure: none of its own; clear wins over load, load overwrites.
module if_skid_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_ir,
  input  logic [31:0] load_pc4,
  output logic [31:0] ir,
  output logic [31:0] pc4,
  output logic        valid
);

  // Capture the stalled instruction; drop it once consumed or flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir    <= IF_NOP;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      ir    <= load_ir;
      pc4   <= load_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem request, feeds IF/ID (IF_FETCH_BUF_EN adds a stall buffer).
// Latency: 0 cycles from imem_ack to IR/PC_plus_4; 1 instr/cycle back-to-back on zero-wait memory.
// Backpressure: stall holds the PC; an ack under stall is buffered (IF_FETCH_BUF_EN) or dropped and refetched.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic [31:0] PC_plus_4,
  output logic        fetch_valid
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        discard;

  logic [31:0] pc_inc;
  logic [31:0] tgt;
  logic        wait_take;

  assign pc_inc = pc + IF_PC_INC;
  assign tgt    = if_align(redirect_target);

  // An ack is deliverable only if nothing flushes or holds it this cycle.
  assign wait_take = (state == WAIT) && imem_ack && !discard && !redirect && !stall;

  // The request is a pure decode of registered state, so it is glitch-free.
  assign imem_req  = (state == WAIT);
  assign imem_addr = pc;

`ifdef IF_FETCH_BUF_EN
  logic [31:0] buf_ir;
  logic [31:0] buf_pc4;
  logic        buf_vld;
  logic        buf_take;
  logic        wait_hold;

  assign wait_hold = (state == WAIT) && imem_ack && !discard && !redirect && stall;
  assign buf_take  = (state == BUF) && buf_vld && !stall && !redirect;

  if_skid_buf u_skid_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_hold),
    .clear    ((state == BUF) && (redirect || !stall)),
    .load_ir  (imem_rdata),
    .load_pc4 (pc_inc),
    .ir       (buf_ir),
    .pc4      (buf_pc4),
    .valid    (buf_vld)
  );
`endif

  // IF/ID payload: live memory data, the buffered word, or a bubble.
  always_comb begin
    IR          = IF_NOP;
    PC_plus_4   = 32'h0;
    fetch_valid = 1'b0;
    if (wait_take) begin
      IR          = imem_rdata;
      PC_plus_4   = pc_inc;
      fetch_valid = 1'b1;
    end
`ifdef IF_FETCH_BUF_EN
    else if (buf_take) begin
      IR          = buf_ir;
      PC_plus_4   = buf_pc4;
      fetch_valid = 1'b1;
    end
`endif
  end

  // Fetch sequencing: redirect beats stall beats advance; a request in flight is never abandoned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
      discard <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            pc <= tgt;
          end else if (!stall) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            if (redirect) begin
              // Live target is newer than anything parked in pend_pc.
              pc      <= tgt;
              discard <= 1'b0;
              state   <= IDLE;
            end else if (discard) begin
              pc      <= pend_pc;
              discard <= 1'b0;
              state   <= IDLE;
            end else if (stall) begin
`ifdef IF_FETCH_BUF_EN
              state <= BUF;
`else
              // Data is dropped; pc is kept so the same word is refetched.
              state <= IDLE;
`endif
            end else begin
              pc <= pc_inc;
            end
          end else if (redirect) begin
            // Remember the target and throw away the in-flight word when it lands.
            discard <= 1'b1;
            pend_pc <= tgt;
          end
        end
`ifdef IF_FETCH_BUF_EN
        BUF: begin
          if (redirect) begin
            pc    <= tgt;
            state <= IDLE;
          end else if (!stall) begin
            pc    <= pc_inc;
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random stall/redirect/wait-state traffic.
// A memory model answers requests with rdata = addr ^ A5A5_0000; a monitor scores every delivered word.
// Reference model: the delivered stream is sequential from the last redirect target (or RESET_PC).
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] MAGIC  = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IR;
  logic [31:0] PC_plus_4;
  logic        fetch_valid;

  int n_chk   = 0;
  int n_err   = 0;
  int n_deliv = 0;
  int starve  = 0;

  int          mem_waits  = 0;
  bit          rand_waits = 1'b0;
  bit          pending    = 1'b0;
  int          wait_left  = 0;
  logic [31:0] pend_addr  = 32'h0;

  // Expected program-order fetch addresses still to be delivered.
  logic [31:0] exp_q[$];
  logic [31:0] e;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .IR              (IR),
    .PC_plus_4       (PC_plus_4),
    .fetch_valid     (fetch_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] b(input logic x);
    return {31'b0, x};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, req, $time);
    end
  endtask

  // Memory: fixed or random wait states, address must stay put until ack.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      pending    = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end else if (imem_req) begin
      if (!pending) begin
        pending   = 1'b1;
        pend_addr = imem_addr;
        wait_left = rand_waits ? int'($urandom_range(0, 3)) : mem_waits;
      end else begin
        chk("addr_hold", imem_addr, pend_addr);
      end
      chk("addr_align", imem_addr & 32'h3, 32'h0);
      if (wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ MAGIC;
        pending    = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_left--;
      end
    end else begin
      if (pending) begin
        chk("req_dropped_before_ack", b(imem_req), 32'h1);
        pending = 1'b0;
      end
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
  end

  // Monitor: reset values, bubble shape, and each delivered word against the stream.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_req", b(imem_req), 32'h0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_ir", IR, 32'h0);
      chk("rst_pc4", PC_plus_4, 32'h0);
      chk("rst_valid", b(fetch_valid), 32'h0);
      starve = 0;
    end else begin
      if (stall || redirect) chk("hold_bubble", b(fetch_valid), 32'h0);
      if (!fetch_valid) begin
        chk("bubble_ir", IR, 32'h0);
        chk("bubble_pc4", PC_plus_4, 32'h0);
        if (!stall && !redirect) begin
          starve++;
          if (starve >= 60) begin
            n_chk++;
            n_err++;
            $display("FAIL starve: %0d unstalled cycles without an instruction, required under 60", starve);
            starve = 0;
          end
        end
      end else begin
        starve = 0;
        n_deliv++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_fetch: pc4=%h delivered, required none", PC_plus_4);
        end else begin
          e = exp_q.pop_front();
          chk("fetch_pc4", PC_plus_4, e + 32'd4);
          chk("fetch_ir", IR, e ^ MAGIC);
          exp_q.push_back(e + 32'd4);
        end
      end
    end
  end

  // One cycle of stimulus; returns at the following falling edge.
  task automatic drive(input bit st, input bit rd, input logic [31:0] tg);
    @(posedge clk);
    #1;
    stall           = st;
    redirect        = rd;
    redirect_target = tg;
    if (rd) begin
      exp_q.delete();
      exp_q.push_back(tg & 32'hFFFF_FFFC);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    n_chk++;
    n_err++;
    $display("FAIL global_timeout: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    bit got;
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    exp_q.push_back(RST_PC);

    // Release: one IDLE cycle, then sequential fetch at one per cycle.
    @(negedge clk);
    chk("rel_idle_req", b(imem_req), 32'h0);
    drive(1'b0, 1'b0, $urandom);
    chk("c2_req", b(imem_req), 32'h1);
    chk("c2_addr", imem_addr, 32'h0);
    chk("c2_valid", b(fetch_valid), 32'h1);
    chk("c2_pc4", PC_plus_4, 32'h4);
    drive(1'b0, 1'b0, $urandom);
    chk("c3_addr", imem_addr, 32'h4);
    chk("c3_pc4", PC_plus_4, 32'h8);

    // Redirect on the ack for 0x8: bubble, one IDLE, then 0x100.
    drive(1'b0, 1'b1, 32'h0000_0100);
    chk("redir_addr", imem_addr, 32'h8);
    chk("redir_ir", IR, 32'h0);
    drive(1'b0, 1'b0, $urandom);
    chk("redir_idle_req", b(imem_req), 32'h0);
    drive(1'b0, 1'b0, $urandom);
    chk("redir_tgt_addr", imem_addr, 32'h100);
    chk("redir_tgt_pc4", PC_plus_4, 32'h104);
    mem_waits = 3;

    // Three-wait memory, redirect in the second wait cycle.
    drive(1'b0, 1'b0, $urandom);
    chk("w1_addr", imem_addr, 32'h104);
    drive(1'b0, 1'b1, 32'h0000_0200);
    chk("w2_addr", imem_addr, 32'h104);
    drive(1'b0, 1'b0, $urandom);
    chk("w3_req", b(imem_req), 32'h1);
    chk("w3_addr", imem_addr, 32'h104);
    drive(1'b0, 1'b0, $urandom);
    chk("wack_addr", imem_addr, 32'h104);
    chk("wack_valid", b(fetch_valid), 32'h0);
    mem_waits = 0;
    drive(1'b0, 1'b0, $urandom);
    chk("wdisc_idle_req", b(imem_req), 32'h0);
    drive(1'b0, 1'b0, $urandom);
    chk("wtgt_addr", imem_addr, 32'h200);
    chk("wtgt_pc4", PC_plus_4, 32'h204);

    // Stall for three cycles covering the ack for 0x204.
    drive(1'b1, 1'b0, $urandom);
    chk("stall_ack_addr", imem_addr, 32'h204);
    chk("stall_ack_valid", b(fetch_valid), 32'h0);
    drive(1'b1, 1'b0, $urandom);
    drive(1'b1, 1'b0, $urandom);
`ifdef IF_FETCH_BUF_EN
    drive(1'b0, 1'b0, $urandom);
    chk("buf_valid", b(fetch_valid), 32'h1);
    chk("buf_ir", IR, 32'h204 ^ MAGIC);
    chk("buf_pc4", PC_plus_4, 32'h208);
    chk("buf_no_req", b(imem_req), 32'h0);
    drive(1'b0, 1'b0, $urandom);
    drive(1'b0, 1'b0, $urandom);
    chk("buf_next_addr", imem_addr, 32'h208);
`else
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      drive(1'b0, 1'b0, $urandom);
      if (imem_req) got = 1'b1;
    end
    if (!got) begin
      n_chk++;
      n_err++;
      $display("FAIL refetch_timeout: no request within 6 cycles after stall");
    end else begin
      chk("refetch_addr", imem_addr, 32'h204);
      chk("refetch_pc4", PC_plus_4, 32'h208);
    end
`endif

    // Wrap: low target bits ignored, pc+4 wraps to 0.
    drive(1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_redir_valid", b(fetch_valid), 32'h0);
    drive(1'b0, 1'b0, $urandom);
    chk("wrap_idle_req", b(imem_req), 32'h0);
    drive(1'b0, 1'b0, $urandom);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc4", PC_plus_4, 32'h0);
    drive(1'b0, 1'b0, $urandom);
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_next_pc4", PC_plus_4, 32'h4);
    mem_waits = 2;

    // Reset in the middle of a waited request.
    drive(1'b0, 1'b0, $urandom);
    chk("mid_req", b(imem_req), 32'h1);
    chk("mid_addr", imem_addr, 32'h4);
    @(posedge clk);
    #3 reset = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_req", b(imem_req), 32'h0);
    chk("arst_addr", imem_addr, RST_PC);
    chk("arst_ir", IR, 32'h0);
    chk("arst_pc4", PC_plus_4, 32'h0);
    chk("arst_valid", b(fetch_valid), 32'h0);
    mem_waits = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.push_back(RST_PC);
    @(negedge clk);
    chk("rerel_idle_req", b(imem_req), 32'h0);
    drive(1'b0, 1'b0, $urandom);
    chk("rerel_req", b(imem_req), 32'h1);
    chk("rerel_addr", imem_addr, RST_PC);

    // Random traffic scored by the monitor against the stream model.
    rand_waits = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bit          st;
      bit          rd;
      logic [31:0] tg;
      st = ($urandom_range(0, 5) == 0);
      rd = ($urandom_range(0, 14) == 0);
      tg = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      drive(st, rd, tg);
    end
    for (int c = 0; c < 10; c++) drive(1'b0, 1'b0, $urandom);
    chk("min_deliveries", b(n_deliv >= 500), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
